// File: rtl/nios_accelerometer_pio_pkg.sv
// Shared constants for the accelerometer/KEY input PIO: register map,
// edge-capture selection codes and the edge-selection helper.
package nios_accelerometer_pio_pkg;

  // Word addresses on the Avalon-MM slave
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_UNUSED = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  // Which debounced transitions are latched into the edge-capture register
  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

  // Picks the capture strobe for one bit from its rise/fall strobes
  function automatic logic edge_select(input int edgeType, input logic rise, input logic fall);
    logic sel;
    sel = 1'b0;
    if (edgeType == EDGE_FALL) begin
      sel = fall;
    end else if (edgeType == EDGE_RISE) begin
      sel = rise;
    end else if (edgeType == EDGE_ANY) begin
      sel = rise | fall;
    end
    return sel;
  endfunction

endpackage

// File: rtl/nios_accelerometer_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and debounced level.
// The rise/fall strobes are combinational and high during the cycle whose
// closing edge updates the debounced level, so the parent can capture the
// transition on that very same edge.
module nios_accelerometer_debounce_bit
  import nios_accelerometer_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  // The synchronised value has differed long enough: take it this edge
  assign w_accept = (r_sync2 != r_db) && (r_cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous board pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive differing cycles; any bounce back restarts from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db  <= IDLE_LEVEL;
      r_cnt <= '0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_db  <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_db   = r_db;
  assign o_rise = w_accept & r_sync2;
  assign o_fall = w_accept & ~r_sync2;

endmodule

// File: rtl/nios_accelerometer_key_pio_in.sv
// Avalon-MM input PIO for KEY/SW pins: per-bit debounce, sticky edge
// capture with write-1-to-clear, interrupt mask and a level IRQ.
module nios_accelerometer_key_pio_in
  import nios_accelerometer_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wrEn;
  logic             w_unusedWrite;
  logic [WIDTH-1:0] r_irqMask;
  logic [WIDTH-1:0] r_edgeCap;

  // Bits above WIDTH are don't-care on writes
  assign w_unusedWrite = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nios_accelerometer_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (in_port[g]),
      .o_db    (w_db[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
    assign w_set[g] = edge_select(EDGE_TYPE, w_rise[g], w_fall[g]);
  end

  assign w_wrEn = chipselect & ~write_n;
  assign w_clr  = (w_wrEn && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqMask <= '0;
    end else if (w_wrEn && (address == ADDR_MASK)) begin
      r_irqMask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky edge capture; a new edge beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgeCap <= '0;
    end else begin
      r_edgeCap <= (r_edgeCap & ~w_clr) | w_set;
    end
  end

  // Zero-wait read mux, independent of chipselect and free of side effects
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = w_db;
      ADDR_MASK:   readdata[WIDTH-1:0] = r_irqMask;
      ADDR_EDGE:   readdata[WIDTH-1:0] = r_edgeCap;
      ADDR_UNUSED: readdata = '0;
      default:     readdata = '0;
    endcase
  end

  assign irq = |(r_edgeCap & r_irqMask);

endmodule

// File: tb/tb_nios_accelerometer_key_pio_in.sv
// Self-checking bench for the input PIO (WIDTH=4, DEBOUNCE_CYCLES=4,
// falling-edge capture, idle-high pins). Expected values come from a
// window model: a debounced bit flips once the last DEBOUNCE_CYCLES
// synchronised samples all disagree with it.
`timescale 1ns/100ps
module tb_nios_accelerometer_key_pio_in;

  localparam int WIDTH = 4;
  localparam int DB    = 4;
  localparam int HD    = DB + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'hF;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [3:0] mDb;
  logic [3:0] mMask;
  logic [3:0] mCap;
  logic [3:0] hist [HD];

  nios_accelerometer_key_pio_in #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DB),
    .EDGE_TYPE       (0),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mDb   = 4'hF;
    mMask = 4'h0;
    mCap  = 4'h0;
    for (int i = 0; i < HD; i++) hist[i] = 4'hF;
  endtask

  // Reference behaviour at one rising edge, using the inputs present at it
  task automatic modelEdge();
    logic [3:0] newDb;
    logic [3:0] setBits;
    logic       allFlip;
    if (!reset_n) begin
      modelReset();
      return;
    end
    for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = in_port;
    newDb   = mDb;
    setBits = 4'h0;
    for (int b = 0; b < WIDTH; b++) begin
      allFlip = 1'b1;
      for (int j = 2; j < HD; j++) if (hist[j][b] == mDb[b]) allFlip = 1'b0;
      if (allFlip) begin
        newDb[b]   = ~mDb[b];
        setBits[b] = mDb[b];
      end
    end
    if (chipselect && !write_n) begin
      if (address == 2'd2) mMask = writedata[3:0];
      if (address == 2'd3) mCap  = mCap & ~writedata[3:0];
    end
    mCap = mCap | setBits;
    mDb  = newDb;
  endtask

  task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #0.5;
    checkOutput(tag, readdata, exp);
  endtask

  task automatic checkIrq(input string tag, input logic exp);
    checkOutput(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // One clock edge: update the model, drop the write strobe, compare everything
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    modelEdge();
    #0.5;
    chipselect = 1'b0;
    write_n    = 1'b1;
    checkIrq($sformatf("%s.irq", tag), |(mCap & mMask));
    checkReg($sformatf("%s.data", tag), 2'd0, {28'd0, mDb});
    checkReg($sformatf("%s.addr1", tag), 2'd1, 32'd0);
    checkReg($sformatf("%s.mask", tag), 2'd2, {28'd0, mMask});
    checkReg($sformatf("%s.edge", tag), 2'd3, {28'd0, mCap});
  endtask

  task automatic doWrite(input string tag, input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    applyStimulus(tag);
  endtask

  initial begin
    int r;
    modelReset();

    // Reset state
    repeat (3) applyStimulus("rst");
    reset_n = 1'b1;
    applyStimulus("idle");
    checkReg("rst.data.k", 2'd0, 32'h0000000F);
    checkReg("rst.mask.k", 2'd2, 32'h0);
    checkReg("rst.edge.k", 2'd3, 32'h0);
    checkIrq("rst.irq.k", 1'b0);

    // Press KEY0: debounced value lands on the 6th edge
    in_port = 4'hE;
    for (int e = 1; e <= 5; e++) applyStimulus($sformatf("press.e%0d", e));
    checkReg("press.e5.data.k", 2'd0, 32'hF);
    applyStimulus("press.e6");
    checkReg("press.e6.data.k", 2'd0, 32'hE);
    checkReg("press.e6.edge.k", 2'd3, 32'h1);
    checkIrq("press.e6.irq.k", 1'b0);
    doWrite("mask1", 2'd2, 32'h1);
    checkIrq("mask1.irq.k", 1'b1);

    // Release KEY0: rising edge is not captured, old capture remains
    in_port = 4'hF;
    for (int e = 1; e <= 8; e++) applyStimulus("release0");
    checkReg("release0.data.k", 2'd0, 32'hF);
    checkReg("release0.edge.k", 2'd3, 32'h1);

    // Clear the capture
    doWrite("w1c0", 2'd3, 32'h1);
    checkReg("w1c0.edge.k", 2'd3, 32'h0);
    checkIrq("w1c0.irq.k", 1'b0);

    // Glitch shorter than the debounce window
    in_port = 4'hE;
    repeat (3) applyStimulus("glitch.low");
    in_port = 4'hF;
    repeat (8) applyStimulus("glitch.high");
    checkReg("glitch.data.k", 2'd0, 32'hF);
    checkReg("glitch.edge.k", 2'd3, 32'h0);

    // Clear of bit1 on the same edge its fall is captured: set wins
    doWrite("mask3", 2'd2, 32'h3);
    in_port = 4'hD;
    for (int e = 1; e <= 5; e++) applyStimulus("race.press");
    doWrite("race.w1c", 2'd3, 32'h2);
    checkReg("race.edge.k", 2'd3, 32'h2);
    checkIrq("race.irq.k", 1'b1);
    in_port = 4'hF;
    repeat (8) applyStimulus("race.release");
    doWrite("race.clear", 2'd3, 32'hF);

    // Reset at count 2 of a press; a full recount follows release
    in_port = 4'hE;
    repeat (4) applyStimulus("midrst.press");
    reset_n = 1'b0;
    modelReset();
    checkReg("midrst.async.data.k", 2'd0, 32'hF);
    repeat (2) applyStimulus("midrst.held");
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) applyStimulus($sformatf("midrst.e%0d", e));
    checkReg("midrst.e5.data.k", 2'd0, 32'hF);
    applyStimulus("midrst.e6");
    checkReg("midrst.e6.data.k", 2'd0, 32'hE);

    // Writes to data and unused addresses change nothing
    doWrite("wr.addr0", 2'd0, 32'hFFFFFFFF);
    doWrite("wr.addr1", 2'd1, 32'hFFFFFFFF);
    checkReg("wr.data.k", 2'd0, 32'hE);
    checkReg("wr.mask.k", 2'd2, 32'h0);
    checkReg("wr.edge.k", 2'd3, 32'h1);

    // Randomised pins and bus traffic against the model
    $display("[TB] random phase");
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 7));
      if (r < 2) in_port[$urandom_range(0, 3)] = ~in_port[$urandom_range(0, 3)];
      r = int'($urandom_range(0, 5));
      if (r == 0) begin
        doWrite("rnd.wr", 2'($urandom_range(0, 3)), $urandom);
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = (r == 1) ? 1'b1 : 1'b1;
        address    = 2'($urandom_range(0, 3));
        writedata  = $urandom;
        applyStimulus("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
